// File: rtl/mac_writeback.sv
// mac_writeback: keeps the MAC beats that end an accumulation, requantises them
// (shift, optional ReLU, saturate), queues them in a small FIFO and streams them
// to output memory, reporting each completed write with a one-cycle pulse.
module mac_writeback #(
  parameter int unsigned ACCUMULATOR_WIDTH = 32,
  parameter int unsigned OUTPUT_WIDTH      = 16,
  parameter int unsigned OUTPUT_SCALE      = 0,
  parameter int unsigned ADDR_WIDTH        = 10,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                                clk,
  input  logic                                arst_in,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_last,
  input  logic signed [ACCUMULATOR_WIDTH-1:0] in_data,
  input  logic [31:0]                         in_ch,
  input  logic                                relu_en,
  input  logic                                clear_stats,
  output logic                                mem_write_valid,
  input  logic                                mem_write_ready,
  output logic [ADDR_WIDTH-1:0]               mem_write_addr,
  output logic signed [OUTPUT_WIDTH-1:0]      mem_write_data,
  output logic                                out_written_to_mem,
  output logic [15:0]                         written_count,
  output logic                                sat_flag,
  output logic                                empty
);

  localparam int unsigned AW    = ACCUMULATOR_WIDTH;
  localparam int unsigned OW    = OUTPUT_WIDTH;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Saturation bounds of the output word, expressed at accumulator width.
  localparam logic signed [AW-1:0] SAT_MAX = AW'((longint'(1) <<< (OW - 1)) - longint'(1));
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(longint'(1) <<< (OW - 1)));

  logic [ADDR_WIDTH-1:0]     addr_q [FIFO_DEPTH];
  logic signed [OW-1:0]      data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          count_q;
  logic                      written_q;
  logic [15:0]               written_count_q;
  logic                      sat_q;

  logic                      full_c, push_c, pop_c;
  logic signed [AW-1:0]      shifted_c;
  logic signed [OW-1:0]      q_data_c;
  logic                      q_sat_c;
  logic                      unused_ch_c;

  // Only the low address bits of the channel tag select the memory word.
  assign unused_ch_c = ^in_ch[31:ADDR_WIDTH];

  // Handshakes and status are derived from occupancy alone.
  assign full_c          = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty           = (count_q == '0);
  assign in_ready        = !full_c;
  assign mem_write_valid = !empty;
  assign push_c          = in_valid && in_ready && in_last;
  assign pop_c           = mem_write_valid && mem_write_ready;

  assign mem_write_addr     = addr_q[rd_ptr_q];
  assign mem_write_data     = data_q[rd_ptr_q];
  assign out_written_to_mem = written_q;
  assign written_count      = written_count_q;
  assign sat_flag           = sat_q;

  // Requantise the incoming accumulator: arithmetic shift, ReLU, saturate.
  always_comb begin
    shifted_c = in_data >>> OUTPUT_SCALE;
    q_sat_c   = 1'b0;
    q_data_c  = shifted_c[OW-1:0];
    if (relu_en && shifted_c[AW-1]) begin
      shifted_c = '0;
      q_data_c  = '0;
    end
    if (shifted_c > SAT_MAX) begin
      q_data_c = SAT_MAX[OW-1:0];
      q_sat_c  = 1'b1;
    end else if (shifted_c < SAT_MIN) begin
      q_data_c = SAT_MIN[OW-1:0];
      q_sat_c  = 1'b1;
    end
  end

  // Circular result queue plus the registered write-completion pulse.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      written_q <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      written_q <= pop_c;
      if (push_c) begin
        addr_q[wr_ptr_q] <= in_ch[ADDR_WIDTH-1:0];
        data_q[wr_ptr_q] <= q_data_c;
        wr_ptr_q         <= PTR_W'(wr_ptr_q + PTR_W'(1));
      end
      if (pop_c) begin
        rd_ptr_q <= PTR_W'(rd_ptr_q + PTR_W'(1));
      end
      if (push_c && !pop_c) begin
        count_q <= CNT_W'(count_q + CNT_W'(1));
      end else if (!push_c && pop_c) begin
        count_q <= CNT_W'(count_q - CNT_W'(1));
      end
    end
  end

  // Write counter and sticky saturation flag; a clear overrides that cycle's events.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      written_count_q <= '0;
      sat_q           <= 1'b0;
    end else if (clear_stats) begin
      written_count_q <= '0;
      sat_q           <= 1'b0;
    end else begin
      if (pop_c) begin
        written_count_q <= 16'(written_count_q + 16'd1);
      end
      if (push_c && q_sat_c) begin
        sat_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_writeback.sv
// Directed bench for mac_writeback: two instances (shift 0 and shift 4) share
// stimulus; expected values are hand-computed constants.
module tb_mac_writeback;

  logic        clk = 1'b0;
  logic        arst_in;
  logic        in_valid, in_last, relu_en, clear_stats, mem_write_ready;
  logic signed [31:0] in_data;
  logic [31:0] in_ch;

  logic        a_in_ready, a_wvalid, a_written, a_sat, a_empty;
  logic [9:0]  a_waddr;
  logic signed [15:0] a_wdata;
  logic [15:0] a_count;

  logic        b_in_ready, b_wvalid, b_written, b_sat, b_empty;
  logic [9:0]  b_waddr;
  logic signed [15:0] b_wdata;
  logic [15:0] b_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mac_writeback #(.OUTPUT_SCALE(0)) u_dut (
    .clk(clk), .arst_in(arst_in), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_last(in_last), .in_data(in_data), .in_ch(in_ch), .relu_en(relu_en),
    .clear_stats(clear_stats), .mem_write_valid(a_wvalid),
    .mem_write_ready(mem_write_ready), .mem_write_addr(a_waddr),
    .mem_write_data(a_wdata), .out_written_to_mem(a_written),
    .written_count(a_count), .sat_flag(a_sat), .empty(a_empty)
  );

  mac_writeback #(.OUTPUT_SCALE(4)) u_dut_s4 (
    .clk(clk), .arst_in(arst_in), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_last(in_last), .in_data(in_data), .in_ch(in_ch), .relu_en(relu_en),
    .clear_stats(clear_stats), .mem_write_valid(b_wvalid),
    .mem_write_ready(mem_write_ready), .mem_write_addr(b_waddr),
    .mem_write_data(b_wdata), .out_written_to_mem(b_written),
    .written_count(b_count), .sat_flag(b_sat), .empty(b_empty)
  );

  // Single comparison point: counts the check and reports any mismatch.
  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic v, input logic last, input int data,
                          input int ch, input logic relu);
    in_valid = v;
    in_last  = last;
    in_data  = data;
    in_ch    = 32'(ch);
    relu_en  = relu;
  endtask

  initial begin
    arst_in = 1'b1;
    set_beat(1'b0, 1'b0, 0, 0, 1'b0);
    clear_stats = 1'b0;
    mem_write_ready = 1'b0;
    #12;

    // Reset values
    check("rst_in_ready", a_in_ready, 1);
    check("rst_empty",    a_empty, 1);
    check("rst_valid",    a_wvalid, 0);
    check("rst_addr",     a_waddr, 0);
    check("rst_data",     a_wdata, 0);
    check("rst_written",  a_written, 0);
    check("rst_count",    a_count, 0);
    check("rst_sat",      a_sat, 0);

    @(negedge clk);
    arst_in = 1'b0;
    tick();

    // Single beat, one-cycle latency to head, then written pulse
    mem_write_ready = 1'b1;
    set_beat(1'b1, 1'b1, 1234, 5, 1'b0);
    tick();
    set_beat(1'b0, 1'b0, 0, 0, 1'b0);
    check("t1_valid", a_wvalid, 1);
    check("t1_addr",  a_waddr, 5);
    check("t1_data",  $signed(a_wdata), 1234);
    check("t1_pulse_early", a_written, 0);
    tick();
    check("t1_pulse", a_written, 1);
    check("t1_count", a_count, 1);
    check("t1_empty", a_empty, 1);

    // Non-last beats are dropped
    for (int i = 0; i < 3; i++) begin
      set_beat(1'b1, 1'b0, 99, 1, 1'b0);
      tick();
      check("t2_drop_empty", a_empty, 1);
    end
    set_beat(1'b1, 1'b1, 7, 2, 1'b0);
    tick();
    set_beat(1'b0, 1'b0, 0, 0, 1'b0);
    check("t2_data", $signed(a_wdata), 7);
    check("t2_count_pre", a_count, 1);
    tick();
    check("t2_pulse", a_written, 1);
    check("t2_count", a_count, 2);
    tick();
    check("t2_pulse_once", a_written, 0);
    check("t2_count_hold", a_count, 2);

    // Saturation high/low and ReLU
    set_beat(1'b1, 1'b1, 40000, 3, 1'b0);
    tick();
    check("t3_hi", $signed(a_wdata), 32767);
    check("t3_sat", a_sat, 1);
    set_beat(1'b1, 1'b1, -40000, 3, 1'b0);
    tick();
    check("t3_lo", $signed(a_wdata), -32768);
    set_beat(1'b1, 1'b1, -5, 3, 1'b1);
    tick();
    set_beat(1'b0, 1'b0, 0, 0, 1'b0);
    check("t3_relu", $signed(a_wdata), 0);
    tick();
    check("t3_count", a_count, 5);
    check("t3_sat_sticky", a_sat, 1);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("t3_clr_sat", a_sat, 0);
    check("t3_clr_count", a_count, 0);

    // Shift by 4 rounds toward minus infinity
    set_beat(1'b1, 1'b1, -33, 6, 1'b0);
    tick();
    set_beat(1'b0, 1'b0, 0, 0, 1'b0);
    check("t4_s4_data", $signed(b_wdata), -3);
    check("t4_s0_data", $signed(a_wdata), -33);
    tick();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;

    // Backpressure: fill the queue, then drain in order
    mem_write_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_ready_before", a_in_ready, 1);
      set_beat(1'b1, 1'b1, 100 + 10 * i, i, 1'b0);
      tick();
    end
    set_beat(1'b0, 1'b0, 0, 0, 1'b0);
    check("t5_full", a_in_ready, 0);
    tick();
    check("t5_head_addr", a_waddr, 0);
    check("t5_head_data", $signed(a_wdata), 100);
    check("t5_no_pulse", a_written, 0);
    mem_write_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_drain_addr", a_waddr, longint'(i));
      check("t5_drain_data", $signed(a_wdata), longint'(100 + 10 * i));
      tick();
      check("t5_drain_pulse", a_written, 1);
    end
    check("t5_count", a_count, 4);
    check("t5_empty", a_empty, 1);
    tick();
    check("t5_pulse_end", a_written, 0);

    // Asynchronous reset with entries queued
    mem_write_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_beat(1'b1, 1'b1, 50 + i, 8 + i, 1'b0);
      tick();
    end
    set_beat(1'b0, 1'b0, 0, 0, 1'b0);
    check("t6_queued", a_wvalid, 1);
    #2;
    arst_in = 1'b1;
    #1;
    check("t6_empty", a_empty, 1);
    check("t6_valid", a_wvalid, 0);
    check("t6_count", a_count, 0);
    check("t6_ready", a_in_ready, 1);
    tick();
    @(negedge clk);
    arst_in = 1'b0;
    mem_write_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_no_stale_pulse", a_written, 0);
      check("t6_no_stale_valid", a_wvalid, 0);
    end
    check("t6_count_after", a_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
